// File: rtl/egress_buffer_pkg.sv
// Shared types for the switch egress buffer: switch-side and MAC-side stream
// structs, the data width, the write FSM states and drop-cause indices.
package egress_buffer_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int DEST_WIDTH = 4;
  // Stored RAM word is {tlast, tdata}.
  localparam int WORD_WIDTH = DATA_WIDTH + 1;

  localparam int DROP_RUNT     = 0;
  localparam int DROP_OVERFLOW = 1;
  localparam int DROP_ABORT    = 2;
  localparam int DROP_DEST     = 3;
  localparam int DROP_CAUSES   = 4;

  typedef struct packed {
    logic                  tvalid;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic [DEST_WIDTH-1:0] tdest;
  } axis_d_source_t;

  typedef struct packed {
    logic tready;
  } axis_d_sink_t;

  typedef struct packed {
    logic                  tvalid;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
  } axis_source_t;

  typedef struct packed {
    logic tready;
  } axis_sink_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DISCARD = 2'd2
  } wr_state_e;

endpackage

// File: rtl/egress_buffer_frame_ram.sv
// Simple dual-port frame store: one write port, one read port with a
// registered output that holds its value while rd_en is low.
module egress_frame_ram #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 33
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/egress_buffer.sv
// Store-and-forward egress buffer for one switch output port; only committed
// frames are replayed. Define DROP_STATS_EN to add per-cause drop counters.
module egress_buffer
  import egress_buffer_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 11,
  parameter logic [DEST_WIDTH-1:0] PORT_ID         = '0,
  parameter int                    MIN_FRAME_WORDS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  axis_d_source_t      ingress_source,
  output axis_d_sink_t        ingress_sink,
  input  logic                abort,
  output axis_source_t        egress_source,
  input  axis_sink_t          egress_sink,
  output logic [ADDR_WIDTH:0] frame_count,
  output logic                empty
`ifdef DROP_STATS_EN
  ,
  output logic [15:0]         drop_runt,
  output logic [15:0]         drop_overflow,
  output logic [15:0]         drop_abort,
  output logic [15:0]         drop_dest
`endif
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE   = 1;
  localparam logic [ADDR_WIDTH:0] MIN_WORDS = MIN_FRAME_WORDS[ADDR_WIDTH:0];

  wr_state_e state_q, state_d;
  logic [ADDR_WIDTH:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0] commit_q, commit_d;
  logic [ADDR_WIDTH:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0] word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH:0] frame_count_q, frame_count_d;
  logic                run_q;
  logic                ram_vld_q, ram_vld_d;
  logic                out_vld_q, out_vld_d;
  logic [WORD_WIDTH-1:0] out_word_q, out_word_d;

  logic                   full;
  logic                   in_ready;
  logic                   beat;
  logic                   dest_ok;
  logic                   wr_en;
  logic                   commit_now;
  logic [ADDR_WIDTH:0]    beats_after;
  logic [DROP_CAUSES-1:0] drop_inc;

  logic                   rd_en;
  logic                   out_ready;
  logic                   move;
  logic                   eg_last_hs;
  logic [WORD_WIDTH-1:0]  ram_rd_data;

  assign full = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);

  // run_q keeps tready low through reset and the first cycle after release.
  assign in_ready    = run_q && !((state_q == ST_IDLE) && full);
  assign beat        = ingress_source.tvalid && in_ready;
  assign dest_ok     = (ingress_source.tdest == PORT_ID);
  assign beats_after = word_cnt_q + PTR_ONE;

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    commit_d   = commit_q;
    word_cnt_d = word_cnt_q;
    wr_en      = 1'b0;
    commit_now = 1'b0;
    drop_inc   = '0;
    case (state_q)
      ST_IDLE: begin
        if (beat) begin
          if (!dest_ok) begin
            drop_inc[DROP_DEST] = 1'b1;
            if (!ingress_source.tlast) begin
              state_d = ST_DISCARD;
            end
          end else if (ingress_source.tlast) begin
            if (beats_after >= MIN_WORDS) begin
              wr_en      = 1'b1;
              wptr_d     = wptr_q + PTR_ONE;
              commit_d   = wptr_q + PTR_ONE;
              commit_now = 1'b1;
            end else begin
              drop_inc[DROP_RUNT] = 1'b1;
            end
          end else begin
            wr_en      = 1'b1;
            wptr_d     = wptr_q + PTR_ONE;
            word_cnt_d = PTR_ONE;
            state_d    = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        if (abort) begin
          // Abort outranks a simultaneous tlast beat.
          wptr_d               = commit_q;
          word_cnt_d           = '0;
          state_d              = ST_IDLE;
          drop_inc[DROP_ABORT] = 1'b1;
        end else if (beat && full) begin
          wptr_d                  = commit_q;
          word_cnt_d              = '0;
          drop_inc[DROP_OVERFLOW] = 1'b1;
          state_d                 = ingress_source.tlast ? ST_IDLE : ST_DISCARD;
        end else if (beat) begin
          wr_en = 1'b1;
          if (ingress_source.tlast) begin
            word_cnt_d = '0;
            state_d    = ST_IDLE;
            if (beats_after >= MIN_WORDS) begin
              wptr_d     = wptr_q + PTR_ONE;
              commit_d   = wptr_q + PTR_ONE;
              commit_now = 1'b1;
            end else begin
              wptr_d              = commit_q;
              drop_inc[DROP_RUNT] = 1'b1;
            end
          end else begin
            wptr_d     = wptr_q + PTR_ONE;
            word_cnt_d = beats_after;
          end
        end
      end
      ST_DISCARD: begin
        if (abort || (beat && ingress_source.tlast)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  egress_frame_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (WORD_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wptr_q[ADDR_WIDTH-1:0]),
    .wr_data ({ingress_source.tlast, ingress_source.tdata}),
    .rd_en   (rd_en),
    .rd_addr (rptr_q[ADDR_WIDTH-1:0]),
    .rd_data (ram_rd_data)
  );

  // Two-stage read pipeline: RAM output stage, then the egress register.
  always_comb begin
    out_ready  = !out_vld_q || egress_sink.tready;
    move       = ram_vld_q && out_ready;
    rd_en      = (rptr_q != commit_q) && (!ram_vld_q || move);
    rptr_d     = rptr_q + {{ADDR_WIDTH{1'b0}}, rd_en};
    ram_vld_d  = rd_en || (ram_vld_q && !move);
    out_vld_d  = move || (out_vld_q && !egress_sink.tready);
    out_word_d = move ? ram_rd_data : out_word_q;
    eg_last_hs = out_vld_q && egress_sink.tready && out_word_q[DATA_WIDTH];
    frame_count_d = frame_count_q;
    if (commit_now && !eg_last_hs) begin
      frame_count_d = frame_count_q + PTR_ONE;
    end else if (!commit_now && eg_last_hs) begin
      frame_count_d = frame_count_q - PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      wptr_q        <= '0;
      commit_q      <= '0;
      rptr_q        <= '0;
      word_cnt_q    <= '0;
      frame_count_q <= '0;
      run_q         <= 1'b0;
      ram_vld_q     <= 1'b0;
      out_vld_q     <= 1'b0;
      out_word_q    <= '0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      commit_q      <= commit_d;
      rptr_q        <= rptr_d;
      word_cnt_q    <= word_cnt_d;
      frame_count_q <= frame_count_d;
      run_q         <= 1'b1;
      ram_vld_q     <= ram_vld_d;
      out_vld_q     <= out_vld_d;
      out_word_q    <= out_word_d;
    end
  end

  assign ingress_sink  = axis_d_sink_t'{tready: in_ready};
  assign egress_source = axis_source_t'{
    tvalid: out_vld_q,
    tdata:  out_word_q[DATA_WIDTH-1:0],
    tlast:  out_word_q[DATA_WIDTH]
  };
  assign frame_count = frame_count_q;
  assign empty       = (frame_count_q == '0);

`ifdef DROP_STATS_EN
  logic [DROP_CAUSES-1:0][15:0] drop_cnt;

  for (genvar gi = 0; gi < DROP_CAUSES; gi++) begin : g_drop
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (drop_inc[gi] && (cnt_q != 16'hFFFF)) begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign drop_cnt[gi] = cnt_q;
  end

  assign drop_runt     = drop_cnt[DROP_RUNT];
  assign drop_overflow = drop_cnt[DROP_OVERFLOW];
  assign drop_abort    = drop_cnt[DROP_ABORT];
  assign drop_dest     = drop_cnt[DROP_DEST];
`else
  logic unused_drop_inc;
  assign unused_drop_inc = ^drop_inc;
`endif

endmodule

// File: tb/tb_egress_buffer.sv
// Directed bench for egress_buffer (ADDR_WIDTH=4, PORT_ID=3): reset, latency,
// abort, overflow, runt/dest drops and wrap-around under random backpressure.
module tb_egress_buffer;
  import egress_buffer_pkg::*;

  localparam int AW = 4;
  localparam logic [3:0] PORT  = 4'd3;
  localparam logic [3:0] OTHER = 4'd9;

  logic           clk = 1'b0;
  logic           reset;
  logic           abort;
  axis_d_source_t in_src;
  axis_d_sink_t   in_sink;
  axis_source_t   eg_src;
  axis_sink_t     eg_sink = '0;
  logic [AW:0]    frame_count;
  logic           empty;
`ifdef DROP_STATS_EN
  logic [15:0] drop_runt, drop_overflow, drop_abort, drop_dest;
`endif

  int checks = 0;
  int errors = 0;
  int stalls = 0;
  int rdy_mode = 0;
  logic [32:0] rx_q[$];
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  egress_buffer #(
    .ADDR_WIDTH      (AW),
    .PORT_ID         (PORT),
    .MIN_FRAME_WORDS (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ingress_source (in_src),
    .ingress_sink   (in_sink),
    .abort          (abort),
    .egress_source  (eg_src),
    .egress_sink    (eg_sink),
    .frame_count    (frame_count),
    .empty          (empty)
`ifdef DROP_STATS_EN
    ,
    .drop_runt      (drop_runt),
    .drop_overflow  (drop_overflow),
    .drop_abort     (drop_abort),
    .drop_dest      (drop_dest)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic l, input logic [3:0] dst);
    int n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    in_src.tvalid = 1'b1;
    in_src.tdata  = d;
    in_src.tlast  = l;
    in_src.tdest  = dst;
    while (!ok && n < 64) begin
      @(negedge clk);
      ok = in_sink.tready;
      if (!ok) stalls++;
      @(posedge clk);
      #1;
      n++;
    end
    chk("ingress_handshake", ok, 1);
    in_src.tvalid = 1'b0;
    in_src.tlast  = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [31:0] base, input logic [3:0] dst,
                            input bit with_last);
    for (int i = 0; i < n; i++) begin
      drive_beat(base + 32'(i), with_last && (i == n - 1), dst);
    end
  endtask

  task automatic expect_frame(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({(i == n - 1), base + 32'(i)});
    end
  endtask

  task automatic wait_rx(input int cnt, input int budget);
    int n;
    n = 0;
    while (rx_q.size() < cnt && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic compare_rx(input string tag);
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      chk(tag, rx_q[i], exp_q[i]);
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  // Egress ready driver: 0 = held low, 1 = held high, 2 = random per cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       eg_sink.tready = 1'b0;
        1:       eg_sink.tready = 1'b1;
        default: eg_sink.tready = 1'($urandom_range(1, 0));
      endcase
    end
  end

  // Egress monitor: records handshakes and checks the output is held while stalled.
  initial begin
    logic        stall_prev;
    logic [32:0] held_word;
    stall_prev = 1'b0;
    held_word  = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("eg_hold_valid", eg_src.tvalid, 1);
          chk("eg_hold_word", {eg_src.tlast, eg_src.tdata}, held_word);
        end
        if (eg_src.tvalid && eg_sink.tready) begin
          rx_q.push_back({eg_src.tlast, eg_src.tdata});
        end
        stall_prev = eg_src.tvalid && !eg_sink.tready;
        held_word  = {eg_src.tlast, eg_src.tdata};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset  = 1'b0;
    abort  = 1'b0;
    in_src = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_tready", in_sink.tready, 0);
    chk("rst_eg_tvalid", eg_src.tvalid, 0);
    chk("rst_eg_tlast", eg_src.tlast, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_empty", empty, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(2);

    // Reset mid-frame after 3 beats
    send_frame(3, 32'h0000_0100, PORT, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_in_tready", in_sink.tready, 0);
    chk("midrst_frame_count", frame_count, 0);
    chk("midrst_eg_tvalid", eg_src.tvalid, 0);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    rdy_mode = 1;
    step(10);
    chk("midrst_nothing_out", rx_q.size(), 0);
    chk("midrst_fc_after", frame_count, 0);
    rx_q.delete();

    // 4-beat frame: tvalid appears two cycles after the commit
    send_frame(4, 32'h0000_1000, PORT, 1'b1);
    expect_frame(4, 32'h0000_1000);
    @(negedge clk);
    chk("lat_fc_after_commit", frame_count, 1);
    chk("lat_not_empty", empty, 0);
    chk("lat_tvalid_c0", eg_src.tvalid, 0);
    @(negedge clk);
    chk("lat_tvalid_c1", eg_src.tvalid, 0);
    @(negedge clk);
    chk("lat_tvalid_c2", eg_src.tvalid, 1);
    chk("lat_first_data", eg_src.tdata, 32'h0000_1000);
    wait_rx(4, 50);
    step(3);
    compare_rx("frame4");
    chk("frame4_fc_drained", frame_count, 0);
    chk("frame4_empty", empty, 1);

    // Abort after beat 2 of 5, then a 3-beat frame
    send_frame(2, 32'h0000_2000, PORT, 1'b0);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    send_frame(3, 32'h0000_3000, PORT, 1'b1);
    expect_frame(3, 32'h0000_3000);
    wait_rx(3, 50);
    step(5);
    compare_rx("abort");
    chk("abort_fc", frame_count, 0);
`ifdef DROP_STATS_EN
    chk("drop_abort", drop_abort, 1);
`endif

    // 20-beat frame overflows the 16-entry buffer at beat 17
    stalls = 0;
    send_frame(20, 32'h0000_4000, PORT, 1'b1);
    chk("ovf_no_backpressure", stalls, 0);
    step(4);
    chk("ovf_fc", frame_count, 0);
    chk("ovf_nothing_out", rx_q.size(), 0);
    send_frame(2, 32'h0000_5000, PORT, 1'b1);
    expect_frame(2, 32'h0000_5000);
    wait_rx(2, 50);
    step(5);
    compare_rx("after_ovf");
`ifdef DROP_STATS_EN
    chk("drop_overflow", drop_overflow, 1);
`endif

    // 1-word runt, then a frame for another port
    send_frame(1, 32'h0000_6000, PORT, 1'b1);
    step(4);
    chk("runt_fc", frame_count, 0);
    send_frame(3, 32'h0000_7000, OTHER, 1'b1);
    step(6);
    chk("dest_fc", frame_count, 0);
    chk("runt_dest_nothing_out", rx_q.size(), 0);
    chk("runt_dest_empty", empty, 1);
    rx_q.delete();
`ifdef DROP_STATS_EN
    chk("drop_runt", drop_runt, 1);
    chk("drop_dest", drop_dest, 1);
`endif

    // Three 5-word frames across the wrap with random egress ready
    rdy_mode = 2;
    for (int f = 0; f < 3; f++) begin
      send_frame(5, 32'h0000_8000 + 32'(f * 256), PORT, 1'b1);
      expect_frame(5, 32'h0000_8000 + 32'(f * 256));
    end
    wait_rx(15, 500);
    rdy_mode = 1;
    step(5);
    compare_rx("wrap");
    chk("wrap_fc", frame_count, 0);
    chk("wrap_empty", empty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
